// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter: forwards local flits to a remote FIFO only while it holds credits.
// Optional macro CREDIT_TX_DEACT_EN adds a STOP/RUN/DRAIN link-deactivation FSM driven by link_en.
module noc_credit_tx #(
  parameter  int FLIT_WIDTH = 32,
  parameter  int CREDIT_MAX = 16,
  localparam int CRD_WIDTH  = $clog2(CREDIT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  crd_rtn,
  input  logic                  link_en,
  output logic [CRD_WIDTH-1:0]  crd_cnt,
  output logic                  link_active,
  output logic                  crd_err
);

  localparam logic [CRD_WIDTH-1:0] CRD_FULL = CRD_WIDTH'(CREDIT_MAX);
  localparam logic [CRD_WIDTH-1:0] CRD_ONE  = CRD_WIDTH'(1);

  logic [CRD_WIDTH-1:0]  crd_cnt_q, crd_cnt_d;
  logic                  crd_err_q, crd_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  run;
  logic                  send;

  // ------------------------------------------------------------------------
  // Link activity control
  // ------------------------------------------------------------------------
`ifdef CREDIT_TX_DEACT_EN
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP:  if (link_en) state_d = ST_RUN;
      ST_RUN:   if (!link_en) state_d = ST_DRAIN;
      // Leave DRAIN only once every credit is home and the last push has left the wire.
      ST_DRAIN: if ((crd_cnt_q == CRD_FULL) && !out_valid_q) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  // Without deactivation the link simply comes up on the first edge after reset release.
  logic active_q;
  logic link_en_unused;

  assign link_en_unused = link_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  assign run = active_q;
`endif

  // ------------------------------------------------------------------------
  // Flow control and credit accounting
  // ------------------------------------------------------------------------
  assign in_ready = run && (crd_cnt_q != '0);
  assign send     = in_valid && in_ready;

  always_comb begin
    crd_cnt_d = crd_cnt_q;
    crd_err_d = crd_err_q;
    unique case ({send, crd_rtn})
      2'b10: crd_cnt_d = crd_cnt_q - CRD_ONE;
      2'b01: begin
        // A return with a full counter means the receiver returned more than it was given.
        if (crd_cnt_q == CRD_FULL) begin
          crd_err_d = 1'b1;
        end else begin
          crd_cnt_d = crd_cnt_q + CRD_ONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = send;
    out_flit_d  = out_flit_q;
    if (send) begin
      out_flit_d = in_flit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_cnt_q   <= CRD_FULL;
      crd_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      crd_cnt_q   <= crd_cnt_d;
      crd_err_q   <= crd_err_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_flit    = out_flit_q;
  assign crd_cnt     = crd_cnt_q;
  assign crd_err     = crd_err_q;
  assign link_active = run;

  // The counter can never exceed the receiver depth.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) crd_cnt_q <= CRD_FULL);

endmodule

// File: doc/noc_credit_tx.md
# noc_credit_tx

Credit-based link transmitter that drives the push side of a remote receive FIFO (push/pop FIFO of depth CREDIT_MAX) across a NoC link. It accepts flits from a local valid/ready source, emits at most one flit per cycle only while it holds a credit, and reclaims one credit per pop pulse returned by the receiver. Sits at every router output port and network-interface injection port, one instance per virtual channel.

## Interface
- FLIT_WIDTH, 32, flit payload width in bits
- CREDIT_MAX, 16, receiver FIFO depth = credits held after reset; legal range 1..255
- CRD_WIDTH, $clog2(CREDIT_MAX+1), credit counter width (localparam)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  local source has a flit
- in_flit  input  FLIT_WIDTH  local flit payload
- in_ready  output  1  transmitter accepts flit this cycle
- out_valid  output  1  one-cycle push pulse to remote FIFO
- out_flit  output  FLIT_WIDTH  flit payload to remote FIFO
- crd_rtn  input  1  one-cycle pulse = one remote FIFO pop = one credit returned
- link_en  input  1  request link active (used only with CREDIT_TX_DEACT_EN)
- crd_cnt  output  CRD_WIDTH  credits currently held
- link_active  output  1  FSM in RUN
- crd_err  output  1  sticky credit-overflow error

## Operation
- Send condition: send = in_valid & in_ready; in_ready = (state == RUN) & (crd_cnt != 0); in_ready never depends on in_valid.
- On send: out_valid <= 1, out_flit <= in_flit next edge; otherwise out_valid <= 0, out_flit holds last value.
- Credit counter: send & ~crd_rtn -> cnt-1; crd_rtn & ~send -> cnt+1; both or neither -> unchanged.
- Overflow: crd_rtn & ~send while cnt == CREDIT_MAX -> cnt stays CREDIT_MAX, crd_err <= 1 (sticky until reset). Underflow impossible by construction.
- FSM states (with CREDIT_TX_DEACT_EN): STOP, RUN, DRAIN.
  - STOP: in_ready = 0; link_en = 1 -> RUN.
  - RUN: link_en = 0 -> DRAIN (in_ready drops the same cycle as the transition edge, i.e. next cycle).
  - DRAIN: in_ready = 0; crd_rtn still counted; when crd_cnt == CREDIT_MAX and out_valid == 0 -> STOP. link_en = 1 in DRAIN is ignored until STOP reached.
- crd_rtn is accepted in every state.

## Timing
- Reset values: in_ready 0, out_valid 0, out_flit 0, crd_cnt CREDIT_MAX, link_active 0, crd_err 0, state STOP (RUN without macro); all take effect asynchronously on rst_n low.
- Reset mid-operation: in-flight out_valid cleared immediately; outstanding credits forgotten (receiver is reset in the same domain).
- Latency: flit accepted cycle N -> out_valid/out_flit valid cycle N+1; one flit per cycle sustained while credits > 0.
- Credit returned cycle N -> crd_cnt updated and in_ready usable cycle N+1.
- With crd_cnt == 1 and send + crd_rtn same cycle: cnt stays 1, in_ready stays 1.
- Round trip: with CREDIT_MAX >= link round-trip latency, full throughput.
- STOP -> RUN: link_en high cycle N -> link_active and in_ready (if credits) cycle N+1.

## Configuration
- CREDIT_TX_DEACT_EN defined: STOP/RUN/DRAIN FSM and link_en honoured as above.
- Not defined: no FSM; state fixed RUN after reset; link_active = 1 after reset release; link_en ignored; in_ready = (crd_cnt != 0).

## Test plan
- Reset, CREDIT_MAX=4, link_en=1, in_valid held 1 with flits 0x1..0x6, no crd_rtn -> out_valid on 4 consecutive cycles carrying 0x1..0x4, crd_cnt 4->0, in_ready 0 afterwards.
- From crd_cnt=0, single crd_rtn pulse -> crd_cnt 1 next cycle, exactly one more flit (0x5) sent, crd_cnt back to 0.
- crd_cnt=1, in_valid=1 and crd_rtn=1 every cycle -> one flit per cycle, crd_cnt constant 1.
- crd_cnt=CREDIT_MAX, crd_rtn pulse with no send -> crd_cnt stays 4, crd_err 1 and remains 1 until rst_n low.
- CREDIT_TX_DEACT_EN: 2 credits outstanding, drop link_en -> in_ready 0, link_active 0; two crd_rtn pulses -> STOP; raise link_en -> RUN one cycle later.
- Assert rst_n low mid-burst -> out_valid 0 immediately, crd_cnt = CREDIT_MAX, crd_err 0.
